// File: rtl/instr_encoder_if.sv
// Field-bundle input and encoded-word output channels of the instruction encoder.
// Both channels: a beat transfers on a rising edge where valid && ready; the sender holds
// its payload stable while valid is high and ready is low, and ready never depends on a future valid.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_class;
  logic [2:0]  in_alu_sel;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [31:0] out_instr;

  modport master (
    output in_valid, in_class, in_alu_sel, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_addr, out_instr
  );

  modport slave (
    input  in_valid, in_class, in_alu_sel, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_addr, out_instr
  );
endinterface

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder: packs lw/sw/R-type/addi/beq field bundles into 32-bit words
// and emits them with an auto-incrementing byte address through a one-word output register.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 64,
  parameter int          CNT_W     = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  instr_encoder_if.slave   bus,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             err,
  output logic [1:0]       err_code
);

  localparam logic [2:0] C_LW   = 3'd0;
  localparam logic [2:0] C_SW   = 3'd1;
  localparam logic [2:0] C_R    = 3'd2;
  localparam logic [2:0] C_ADDI = 3'd3;
  localparam logic [2:0] C_BEQ  = 3'd4;

  logic        out_valid_q;
  logic [31:0] out_instr_q;
  logic [31:0] out_addr_q;

  logic        xfer;
  logic        alu_ok;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        imm12_ok;
  logic        imm13_ok;
  logic [1:0]  code;
  logic [31:0] word;

  assign full         = (count == CNT_W'(DEPTH));
  assign bus.in_ready = !clear && !full && (!out_valid_q || bus.out_ready);
  assign xfer         = bus.in_valid && bus.in_ready;

  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_addr  = out_addr_q;

  // 12-bit signed range: bits 31..11 all equal the sign.
  assign imm12_ok = (bus.in_imm[31:11] == {21{bus.in_imm[31]}});
  // 13-bit signed range minus +4095, which cannot be an even branch offset.
  assign imm13_ok = (bus.in_imm[31:12] == {20{bus.in_imm[31]}}) &&
                    (bus.in_imm != 32'h0000_0FFF);

  always_comb begin
    f3     = 3'b000;
    f7     = 7'b0000000;
    alu_ok = 1'b1;
    case (bus.in_alu_sel)
      3'b000:  f3 = 3'b000;
      3'b001:  f7 = 7'b0100000;
      3'b010:  f3 = 3'b111;
      3'b011:  f3 = 3'b110;
      3'b101:  f3 = 3'b010;
      default: alu_ok = 1'b0;
    endcase
  end

  always_comb begin
    code = 2'b00;
    if ((bus.in_class > C_BEQ) || ((bus.in_class == C_R) && !alu_ok)) begin
      code = 2'b01;
    end else if (((bus.in_class == C_LW || bus.in_class == C_SW || bus.in_class == C_ADDI) && !imm12_ok) ||
                 ((bus.in_class == C_BEQ) && !imm13_ok)) begin
      code = 2'b10;
    end else if ((bus.in_class == C_BEQ) && bus.in_imm[0]) begin
      code = 2'b11;
    end
  end

  always_comb begin
    word = 32'h0;
    case (bus.in_class)
      C_LW:    word = {bus.in_imm[11:0], bus.in_rs1, 3'b010, bus.in_rd, 7'b0000011};
      C_SW:    word = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, 3'b010, bus.in_imm[4:0], 7'b0100011};
      C_R:     word = {f7, bus.in_rs2, bus.in_rs1, f3, bus.in_rd, 7'b0110011};
      C_ADDI:  word = {bus.in_imm[11:0], bus.in_rs1, 3'b000, bus.in_rd, 7'b0010011};
      C_BEQ:   word = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1, 3'b000,
                       bus.in_imm[4:1], bus.in_imm[11], 7'b1100011};
      default: word = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_instr_q <= 32'h0;
      out_addr_q  <= BASE_ADDR;
      count       <= '0;
      err         <= 1'b0;
      err_code    <= 2'b00;
    end else if (clear) begin
      out_valid_q <= 1'b0;
      out_instr_q <= 32'h0;
      out_addr_q  <= BASE_ADDR;
      count       <= '0;
      err         <= 1'b0;
      err_code    <= 2'b00;
    end else begin
      // A legal bundle refills the register even while the previous word drains.
      if (xfer && (code == 2'b00)) begin
        out_valid_q <= 1'b1;
        out_instr_q <= word;
        out_addr_q  <= BASE_ADDR + (32'(count) << 2);
        count       <= count + CNT_W'(1);
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (xfer && (code != 2'b00) && !err) begin
        err      <= 1'b1;
        err_code <= code;
      end
    end
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Streaming RISC-V instruction encoder: the opposite direction of the main decoder.
- Accepts decoded instruction fields (class, ALU select, register indices, immediate) over a valid/ready handshake.
- Packs them into 32-bit RV32I words and emits them, with an auto-incrementing byte address, to the instruction-memory write port.
- Used by the program loader and test infrastructure to build instruction images for the single-cycle core. Supports exactly the classes the core decodes: lw, sw, R-type, addi, beq.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first emitted word.
- DEPTH, 64, maximum number of words emitted before full.
- CNT_W, 7, width of count; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous restart: empties the output stage, sets count to 0, clears err.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  encoder can accept a bundle this cycle.
- in_class  input  3  000 lw, 001 sw, 010 R-type, 011 addi, 100 beq; others illegal.
- in_alu_sel  input  3  R-type only: 000 add, 001 sub, 010 and, 011 or, 101 slt; others illegal.
- in_rd  input  5  destination register index.
- in_rs1  input  5  source register 1 index.
- in_rs2  input  5  source register 2 index.
- in_imm  input  32  signed immediate; for beq, a byte offset.
- out_valid  output  1  out_instr/out_addr valid.
- out_ready  input  1  memory writer accepts the word.
- out_addr  output  32  byte address, BASE_ADDR + 4*index.
- out_instr  output  32  encoded instruction.
- count  output  CNT_W  number of legal words accepted since reset/clear.
- full  output  1  count == DEPTH.
- err  output  1  sticky error flag.
- err_code  output  2  01 illegal class/alu_sel, 10 immediate out of range, 11 misaligned beq offset.

Behaviour:
- Reset (rst_n low, async): out_valid=0, out_instr=0, out_addr=BASE_ADDR, count=0, full=0, err=0, err_code=00.
- in_ready = !clear && !full && (!out_valid || out_ready). A transfer occurs when in_valid && in_ready.
- Latency is 1 cycle. A legal transfer in cycle N gives out_valid=1 in cycle N+1, with out_addr=BASE_ADDR+4*count(N) and count incremented.
- The output register holds out_instr and out_addr stable while out_valid && !out_ready. out_valid drops after out_ready unless a new transfer refills the register in the same cycle; back-to-back throughput is 1 word per cycle.
- Encodings (f3 = funct3, f7 = funct7):
  - lw: imm[11:0], rs1, f3=010, rd, 0000011.
  - sw: imm[11:5], rs2, rs1, f3=010, imm[4:0], 0100011.
  - R-type: f7, rs2, rs1, f3, rd, 0110011.
    - add: f3=000, f7=0000000.
    - sub: f3=000, f7=0100000.
    - and: f3=111, f7=0000000.
    - or: f3=110, f7=0000000.
    - slt: f3=010, f7=0000000.
  - addi: imm[11:0], rs1, f3=000, rd, 0010011.
  - beq: imm[12], imm[10:5], rs2, rs1, f3=000, imm[4:1], imm[11], 1100011.
- Fields unused by a class are ignored and do not affect the output.
- Legality checks, in priority order:
  - Illegal class, or R-type with an illegal alu_sel → code 01.
  - lw/sw/addi with in_imm outside -2048..2047, or beq with in_imm outside -4096..4094 → code 10.
  - beq with in_imm[0]=1 → code 11.
- An illegal bundle is still consumed (handshake completes). It produces no output word, count does not increment, and err is set.
  - err_code records the first error only; it is held until clear or reset.
- full asserts the cycle after count reaches DEPTH. in_ready stays low until clear. The word that made the block full still drains normally.
- clear has priority over a simultaneous in_valid; that bundle is not accepted. On the next edge: out_valid=0, with any pending word discarded; count=0; out_addr base returns to BASE_ADDR; err/err_code are cleared.
- Reset asserted mid-stream aborts immediately. All state returns to reset values with no partial output.

Test Plan:
- addi x1,x0,5, then add x3,x1,x2, then sub x3,x1,x2 with out_ready=1 → out_instr 0x00500093, 0x002081B3, 0x402081B3 on consecutive cycles; out_addr 0x0, 0x4, 0x8; count=3.
- lw x5,8(x2) and sw x5,12(x2) → 0x00812283 and 0x00512623.
- beq x1,x2,-8 → 0xFE208CE3.
- out_ready held 0 for 3 cycles while in_valid stays high → output held at the first word, in_ready=0 during the stall, no word lost or duplicated after release.
- addi with imm=2048 → no output, count unchanged, err=1, err_code=10. A following class=111 → err_code stays 10. clear → err=0.
- DEPTH=4: send 5 legal bundles → 4 words at addresses 0x0–0xC, full=1, in_ready=0 for the 5th. clear together with in_valid → bundle rejected, count=0, next word at 0x0.
